// File: rtl/counter_pkg.sv
// Shared types and defaults for the loop/vector-element down-counter.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loop_cnt_state_t;

endpackage

// File: rtl/loop_down_counter.sv
// Loadable trip-count down-counter: reports remaining count, elapsed index
// and a one-cycle completion pulse to the control FSM.
//
// state | meaning
// IDLE  | no run active; count/index hold last values
// RUN   | counting down, one step per enabled cycle
// DONE  | run finished; done high for this single cycle
module loop_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] index,
  output logic             busy,
  output logic             done
);

  loop_cnt_state_t state_q, state_d;
  logic [WIDTH-1:0] trip_q, trip_d;
  logic [WIDTH-1:0] count_d, index_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      trip_q  <= '0;
      count   <= '0;
      index   <= '0;
    end else begin
      state_q <= state_d;
      trip_q  <= trip_d;
      count   <= count_d;
      index   <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    trip_d  = trip_q;
    count_d = count;
    index_d = index;
    busy    = (state_q == RUN);
    done    = (state_q == DONE);

    // A load restarts from any state, and any enable in the same cycle is dropped.
    if (load) begin
      trip_d  = load_value;
      count_d = load_value;
      index_d = '0;
      state_d = (load_value == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            if (count <= WIDTH'(1)) begin
              count_d = '0;
              index_d = trip_q;
              state_d = DONE;
            end else begin
              count_d = count - WIDTH'(1);
              index_d = index + WIDTH'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
